// File: rtl/adder_pipe_if.sv
// rtl/adder_pipe_if.sv - operand/result handshake bundle for adder_pipe
// The overflow signal exists only when ADDER_PIPE_OVF_EN is defined.
interface adder_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             final_carry_out;
`ifdef ADDER_PIPE_OVF_EN
  logic             overflow;
`endif

  modport master (
`ifdef ADDER_PIPE_OVF_EN
    input  overflow,
`endif
    output in_valid, x, y, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, final_carry_out
  );

  modport slave (
`ifdef ADDER_PIPE_OVF_EN
    output overflow,
`endif
    input  in_valid, x, y, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, final_carry_out
  );
endinterface

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage
// Define ADDER_PIPE_OVF_EN to add the registered signed-overflow output.
module adder_pipe #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic       clk,
  input  logic       rst,
  adder_pipe_if.slave bus
);
  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

  logic advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * CHUNK;
    localparam int W   = (WIDTH - LO < CHUNK) ? (WIDTH - LO) : CHUNK;
    localparam int HI  = LO + W;
    localparam int REM = WIDTH - HI;

    // Operand bits not yet added, right-aligned so this stage's slice sits at bit 0.
    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;
    logic                c_in;
    logic                v_in;
    logic [W:0]          slice;
    logic [HI-1:0]       s_d, s_q;
    logic                c_d, c_q;
    logic                v_d, v_q;

    if (k == 0) begin : g_src
      always_comb begin
        a_in = bus.x;
        b_in = bus.sub ? ~bus.y : bus.y;
        c_in = bus.carry_in ^ bus.sub;
        v_in = bus.in_valid;
      end
    end else begin : g_src
      always_comb begin
        a_in = g_stage[k-1].g_ops.a_q;
        b_in = g_stage[k-1].g_ops.b_q;
        c_in = g_stage[k-1].c_q;
        v_in = g_stage[k-1].v_q;
      end
    end

    always_comb begin
      slice = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};
      c_d   = slice[W];
      v_d   = v_in;
    end

    if (k == 0) begin : g_sum
      always_comb s_d = slice[W-1:0];
    end else begin : g_sum
      always_comb s_d = {slice[W-1:0], g_stage[k-1].s_q};
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_d, a_q;
      logic [REM-1:0] b_d, b_q;

      always_comb begin
        a_d = a_in[WIDTH-LO-1:W];
        b_d = b_in[WIDTH-LO-1:W];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (advance) begin
        s_q <= s_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end

`ifdef ADDER_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_d, ovf_q;

      always_comb ovf_d = (a_in[W-1] == b_in[W-1]) && (slice[W-1] != a_in[W-1]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  // Single global stall: the whole pipe freezes while a result waits.
  assign advance             = bus.out_ready || !g_stage[STAGES-1].v_q;
  assign bus.in_ready        = advance;
  assign bus.out_valid       = g_stage[STAGES-1].v_q;
  assign bus.sum             = g_stage[STAGES-1].s_q;
  assign bus.final_carry_out = g_stage[STAGES-1].c_q;
`ifdef ADDER_PIPE_OVF_EN
  assign bus.overflow        = g_stage[STAGES-1].g_ovf.ovf_q;
`endif
endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe (8/4 and 7/3 instances)
// Overflow is checked only when ADDER_PIPE_OVF_EN is defined.
module tb_adder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       cin;
    logic       sub;
    logic [9:0] e;
  } set8_t;

`ifdef ADDER_PIPE_OVF_EN
  localparam logic [9:0] MASK = 10'h3FF;
`else
  localparam logic [9:0] MASK = 10'h1FF;
`endif

  logic [9:0] exp_q[$];

  adder_pipe_if #(.WIDTH(8)) bus8();
  adder_pipe_if #(.WIDTH(7)) bus7();

  adder_pipe #(.WIDTH(8), .CHUNK(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  adder_pipe #(.WIDTH(7), .CHUNK(3)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic s);
    logic [7:0] be;
    logic       ce;
    logic [8:0] f;
    be = s ? ~b : b;
    ce = s ? ~cin : cin;
    f  = {1'b0, a} + {1'b0, be} + {8'd0, ce};
    return {(a[7] == be[7]) && (f[7] != a[7]), f};
  endfunction

  function automatic logic [9:0] obs8();
`ifdef ADDER_PIPE_OVF_EN
    return {bus8.overflow, bus8.final_carry_out, bus8.sum};
`else
    return {1'b0, bus8.final_carry_out, bus8.sum};
`endif
  endfunction

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s);
    bus8.in_valid = v;
    bus8.x        = a;
    bus8.y        = b;
    bus8.carry_in = c;
    bus8.sub      = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus8.out_valid); end
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready); end
    checks++; if ((obs8() & MASK) !== 10'd0) begin errors++; $display("FAIL reset_result: got %h want 000", obs8()); end
    checks++; if (bus7.out_valid !== 1'b0 || bus7.sum !== 7'd0) begin errors++; $display("FAIL reset_w7: got valid %b sum %0d want 0/0", bus7.out_valid, bus7.sum); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    @(negedge clk);
    bus8.out_ready = 1'b1;
    drive8(1'b1, 8'd10, 8'd2, 1'b0, 1'b0);
    #1;
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b want 1", bus8.in_ready); end
    @(negedge clk);
    drive8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL add_early: got out_valid %b want 0", bus8.out_valid); end
    @(negedge clk);
    #1;
    checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: got out_valid %b want 1", bus8.out_valid); end
    checks++; if ((obs8() & MASK) !== ({1'b0, 1'b0, 8'd12} & MASK)) begin errors++; $display("FAIL add_result: got %h want %h", obs8(), 10'd12); end
    @(negedge clk);
    #1;
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got out_valid %b want 0", bus8.out_valid); end
  endtask

  task automatic test_arith;
    set8_t tab[5];
    int idx = 0;
    int got = 0;
    logic [9:0] e;
    tab[0] = '{x: 8'd128, y: 8'd129, cin: 1'b0, sub: 1'b0, e: {1'b1, 1'b1, 8'd1}};
    tab[1] = '{x: 8'd125, y: 8'd124, cin: 1'b0, sub: 1'b0, e: {1'b1, 1'b0, 8'd249}};
    tab[2] = '{x: 8'd1,   y: 8'd29,  cin: 1'b1, sub: 1'b0, e: {1'b0, 1'b0, 8'd31}};
    tab[3] = '{x: 8'd10,  y: 8'd200, cin: 1'b0, sub: 1'b1, e: {1'b0, 1'b0, 8'd66}};
    tab[4] = '{x: 8'd200, y: 8'd10,  cin: 1'b0, sub: 1'b1, e: {1'b0, 1'b1, 8'd190}};
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      bus8.out_ready = 1'b1;
      if (idx < 5) drive8(1'b1, tab[idx].x, tab[idx].y, tab[idx].cin, tab[idx].sub);
      else bus8.in_valid = 1'b0;
      #1;
      if (bus8.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL arith_extra: unexpected result %h", obs8());
        end else begin
          e = exp_q.pop_front();
          if ((obs8() & MASK) !== (e & MASK)) begin errors++; $display("FAIL arith_result: got %h want %h", obs8() & MASK, e & MASK); end
        end
        got++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        exp_q.push_back(tab[idx].e);
        idx++;
      end
    end
    checks++; if (got != 5) begin errors++; $display("FAIL arith_timeout: got %0d results want 5", got); end
    bus8.in_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    set8_t tab[4];
    int idx = 0;
    int got = 0;
    int stall = -1;
    logic started = 1'b0;
    logic [7:0] held = '0;
    logic [9:0] e;
    for (int i = 0; i < 4; i++) begin
      tab[i].x   = 8'($urandom_range(0, 255));
      tab[i].y   = 8'($urandom_range(0, 255));
      tab[i].cin = 1'($urandom_range(0, 1));
      tab[i].sub = 1'($urandom_range(0, 1));
      tab[i].e   = model8(tab[i].x, tab[i].y, tab[i].cin, tab[i].sub);
    end
    exp_q.delete();
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clk);
      if (bus8.out_valid && stall < 0) begin
        stall = 3;
        held  = bus8.sum;
      end
      bus8.out_ready = (stall <= 0);
      if (idx < 4) drive8(1'b1, tab[idx].x, tab[idx].y, tab[idx].cin, tab[idx].sub);
      else bus8.in_valid = 1'b0;
      #1;
      if (stall > 0) begin
        checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready: got %b want 0", bus8.in_ready); end
        checks++; if (bus8.sum !== held || bus8.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall_hold: got sum %h valid %b want %h 1", bus8.sum, bus8.out_valid, held); end
        stall--;
      end else if (started && !bus8.out_valid) begin
        checks++; errors++; $display("FAIL b2b_gap: got out_valid 0 want 1 after %0d results", got);
      end
      if (bus8.out_valid && bus8.out_ready) begin
        started = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: unexpected result %h", obs8());
        end else begin
          e = exp_q.pop_front();
          if ((obs8() & MASK) !== (e & MASK)) begin errors++; $display("FAIL b2b_result: got %h want %h", obs8() & MASK, e & MASK); end
        end
        got++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        exp_q.push_back(tab[idx].e);
        idx++;
      end
    end
    checks++; if (got != 4 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_count: got %0d results, %0d pending want 4, 0", got, exp_q.size()); end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_duplicate: got out_valid %b want 0", bus8.out_valid); end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus8.out_ready = 1'b1;
    drive8(1'b1, 8'd3, 8'd4, 1'b0, 1'b0);
    @(negedge clk);
    drive8(1'b1, 8'd20, 8'd30, 1'b0, 1'b0);
    @(negedge clk);
    drive8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus8.out_valid !== 1'b1 || bus8.sum !== 8'd7) begin errors++; $display("FAIL rmid_before: got valid %b sum %0d want 1 7", bus8.out_valid, bus8.sum); end
    rst = 1'b1;
    #1;
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus8.out_valid); end
    checks++; if ((obs8() & MASK) !== 10'd0) begin errors++; $display("FAIL rmid_result: got %h want 000", obs8()); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale: got out_valid %b want 0", bus8.out_valid); end
    end
    drive8(1'b1, 8'd50, 8'd60, 1'b0, 1'b0);
    #1;
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", bus8.in_ready); end
    @(negedge clk);
    drive8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_early: got %b want 0", bus8.out_valid); end
    @(negedge clk);
    #1;
    checks++; if (bus8.out_valid !== 1'b1 || bus8.sum !== 8'd110) begin errors++; $display("FAIL rmid_after: got valid %b sum %0d want 1 110", bus8.out_valid, bus8.sum); end
    @(negedge clk);
  endtask

  task automatic test_narrow;
    logic [6:0] tx[3];
    logic [6:0] ty[3];
    logic       ts[3];
    logic [6:0] es[3];
    logic       ec[3];
    tx[0] = 7'd127; ty[0] = 7'd1;  ts[0] = 1'b0; es[0] = 7'd0;   ec[0] = 1'b1;
    tx[1] = 7'd100; ty[1] = 7'd27; ts[1] = 1'b0; es[1] = 7'd127; ec[1] = 1'b0;
    tx[2] = 7'd5;   ty[2] = 7'd9;  ts[2] = 1'b1; es[2] = 7'd124; ec[2] = 1'b0;
    bus7.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus7.in_valid = 1'b1;
      bus7.x = tx[i]; bus7.y = ty[i]; bus7.carry_in = 1'b0; bus7.sub = ts[i];
      #1;
      checks++; if (bus7.in_ready !== 1'b1) begin errors++; $display("FAIL w7_ready[%0d]: got %b want 1", i, bus7.in_ready); end
      @(negedge clk);
      bus7.in_valid = 1'b0;
      #1;
      checks++; if (bus7.out_valid !== 1'b0) begin errors++; $display("FAIL w7_early1[%0d]: got %b want 0", i, bus7.out_valid); end
      @(negedge clk);
      #1;
      checks++; if (bus7.out_valid !== 1'b0) begin errors++; $display("FAIL w7_early2[%0d]: got %b want 0", i, bus7.out_valid); end
      @(negedge clk);
      #1;
      checks++;
      if (bus7.out_valid !== 1'b1 || bus7.sum !== es[i] || bus7.final_carry_out !== ec[i]) begin
        errors++;
        $display("FAIL w7_result[%0d]: got valid %b sum %0d cout %b want 1 %0d %b",
                 i, bus7.out_valid, bus7.sum, bus7.final_carry_out, es[i], ec[i]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    drive8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    bus8.out_ready = 1'b1;
    bus7.in_valid  = 1'b0;
    bus7.x         = '0;
    bus7.y         = '0;
    bus7.carry_in  = 1'b0;
    bus7.sub       = 1'b0;
    bus7.out_ready = 1'b1;
    test_reset();
    test_add();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined add/subtract unit succeeding the fixed 8-bit ripple adder. WIDTH-bit operands are split into CHUNK-bit slices, with one pipeline stage per slice, so the carry chain is registered between slices. A valid/ready handshake lets the unit sit directly in the datapath under back-pressure. A compile-time option adds a signed-overflow flag.

## Interface

- WIDTH, 8: operand and result width; must be at least 2.
- CHUNK, 4: bits added per stage; 1 ≤ CHUNK ≤ WIDTH.
- STAGES (localparam) = ceil(WIDTH/CHUNK): pipeline depth.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  unit accepts operands this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- carry_in  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result this cycle.
- sum  out  WIDTH  result.
- final_carry_out  out  1  carry out of the MSB.
- overflow  out  1  signed overflow; present only with ADDER_PIPE_OVF_EN.

## Operation

- Add: {final_carry_out, sum} = x + y + carry_in. The sum is computed modulo 2^WIDTH.
- Subtract: {final_carry_out, sum} = x + ~y + ~carry_in. This gives sum = x − y − carry_in.
  - final_carry_out = 1 means no borrow.
- Stage k (0-based) adds bits [k·CHUNK +: CHUNK] of the operands using the carry registered by stage k−1.
  - Stage 0 uses the effective carry-in.
  - Not-yet-added upper operand bits and already-produced lower sum bits travel with the stage registers.
  - The last stage may be narrower than CHUNK when WIDTH is not a multiple of CHUNK.
- Each stage holds a valid bit; the last stage's valid bit drives out_valid.
- Global stall: advance = out_ready || !out_valid.
  - in_ready = advance.
  - All stage registers load only when advance = 1.
- An operand set is accepted when in_valid && in_ready.
- A bubble (in_valid = 0 while advance = 1) enters stage 0 with valid = 0.
- Outputs are registered. sum, final_carry_out and overflow hold steady while out_valid && !out_ready.

## Timing

- Reset (asynchronous assert, synchronous release):
  - all valid bits 0, so out_valid = 0 and in_ready = 1;
  - sum = 0, final_carry_out = 0, overflow = 0.
- Latency: an operand set accepted at edge n appears with out_valid = 1 after edge n+STAGES−1, provided there is no stall.
  - STAGES = 1 gives one-register latency.
- Throughput: one result per cycle while out_ready = 1.
- Stall: while out_valid = 1 and out_ready = 0:
  - in_ready = 0;
  - no stage register changes;
  - in-flight operand sets are neither lost nor duplicated.
- Simultaneous accept and drain in the same cycle is legal. The pipeline shifts and occupancy is unchanged.
- in_valid may drop without a handshake. x, y, carry_in and sub are sampled only on accept.
- Reset mid-operation discards every in-flight set. The first accept after release behaves as from idle.
- Carry wrap-around: 0xFF+0x01 with WIDTH = 8 gives sum = 0x00, final_carry_out = 1.

## Configuration

- ADDER_PIPE_OVF_EN defined:
  - The overflow port exists.
  - overflow = (sign of effective A == sign of effective B) && (sign of sum != sign of A).
    - Effective B is ~y when sub = 1.
  - overflow is piped with the final stage and aligned with sum.
- Not defined: the overflow port and its logic are absent. All other behaviour is identical.

## Test plan

Configuration for all cases: WIDTH = 8, CHUNK = 4, STAGES = 2, OVF_EN defined unless stated.

- Add: x = 10, y = 2, cin = 0 → sum = 12, cout = 0, ovf = 0, out_valid exactly 2 edges after accept.
- Carry and overflow:
  - 128+129, cin = 0 → sum = 1, cout = 1, ovf = 1.
  - 125+124 → sum = 249, cout = 0, ovf = 1.
  - 1+29, cin = 1 → sum = 31.
- Subtract: x = 10, y = 200, sub = 1, cin = 0 → sum = 66, cout = 0, ovf = 0. Then x = 200, y = 10 → sum = 190, cout = 1.
- Back-pressure:
  - Stream 4 sets back-to-back.
  - Hold out_ready = 0 for 3 cycles after the first out_valid → in_ready = 0, sum stable.
  - Release → all 4 results arrive in order with no gaps or duplicates.
- Reset mid-flight: accept 2 sets, assert rst between edges → out_valid = 0 and sum = 0 immediately, with no stale result after release.
- WIDTH = 7, CHUNK = 3 (STAGES = 3): 127+1 → sum = 0, cout = 1 after 3 edges. Rebuild without the macro and repeat the add case to confirm sum/cout match.
